// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared state encoding and shift unit function codes
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] FUN_SHR_A = 2'b00;
    localparam logic [1:0] FUN_SHL_A = 2'b01;

    function automatic logic [1:0] fun_for_dir(input logic dir);
        return dir ? FUN_SHL_A : FUN_SHR_A;
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-bit shifter built from repeated single-bit shift unit passes
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_Valid,
    output logic             REQ_Ready,
    input  logic [WIDTH-1:0] REQ_Data,
    input  logic [AW-1:0]    REQ_Amount,
    input  logic             REQ_Dir,
    output logic [WIDTH-1:0] SU_A,
    output logic [WIDTH-1:0] SU_B,
    output logic [1:0]       SU_ALU_FUN,
    output logic             SU_Shift_Enable,
    input  logic [WIDTH-1:0] SU_SHIFT_OUT,
    input  logic             SU_SHIFT_Flag,
    output logic [WIDTH-1:0] RES_Data,
    output logic             RES_Valid,
    output logic             Busy
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_next;
    logic [AW-1:0]    r_count;
    logic [AW-1:0]    w_count_next;
    logic             r_dir;
    logic             w_dir_next;
    logic [WIDTH-1:0] r_res_data;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_work     <= '0;
            r_count    <= '0;
            r_dir      <= 1'b0;
            r_res_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_work  <= w_work_next;
            r_count <= w_count_next;
            r_dir   <= w_dir_next;
            // Result register only changes on the way into DONE, so it holds between operations
            if (w_state_next == ST_DONE) begin
                r_res_data <= w_work_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_work_next  = r_work;
        w_count_next = r_count;
        w_dir_next   = r_dir;
        case (r_state)
            ST_IDLE: begin
                if (REQ_Valid) begin
                    w_work_next  = REQ_Data;
                    w_count_next = REQ_Amount;
                    w_dir_next   = REQ_Dir;
                    w_state_next = (REQ_Amount == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Without the unit's flag the FSM idles here untouched
                if (SU_SHIFT_Flag) begin
                    w_work_next  = SU_SHIFT_OUT;
                    w_count_next = r_count - AW'(1);
                    w_state_next = (r_count == AW'(1)) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        REQ_Ready       = (r_state == ST_IDLE);
        Busy            = (r_state != ST_IDLE);
        SU_Shift_Enable = (r_state == ST_ISSUE);
        SU_ALU_FUN      = (r_state == ST_ISSUE) ? fun_for_dir(r_dir) : FUN_SHR_A;
        SU_A            = r_work;
        SU_B            = '0;
        RES_Valid       = (r_state == ST_DONE);
        RES_Data        = r_res_data;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed vector bench for shift_sequencer with a registered shift unit model
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int AW    = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             REQ_Valid = 1'b0;
    logic             REQ_Ready;
    logic [WIDTH-1:0] REQ_Data = '0;
    logic [AW-1:0]    REQ_Amount = '0;
    logic             REQ_Dir = 1'b0;
    logic [WIDTH-1:0] SU_A;
    logic [WIDTH-1:0] SU_B;
    logic [1:0]       SU_ALU_FUN;
    logic             SU_Shift_Enable;
    logic [WIDTH-1:0] SU_SHIFT_OUT;
    logic             SU_SHIFT_Flag;
    logic [WIDTH-1:0] RES_Data;
    logic             RES_Valid;
    logic             Busy;

    shift_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .REQ_Valid       (REQ_Valid),
        .REQ_Ready       (REQ_Ready),
        .REQ_Data        (REQ_Data),
        .REQ_Amount      (REQ_Amount),
        .REQ_Dir         (REQ_Dir),
        .SU_A            (SU_A),
        .SU_B            (SU_B),
        .SU_ALU_FUN      (SU_ALU_FUN),
        .SU_Shift_Enable (SU_Shift_Enable),
        .SU_SHIFT_OUT    (SU_SHIFT_OUT),
        .SU_SHIFT_Flag   (SU_SHIFT_Flag),
        .RES_Data        (RES_Data),
        .RES_Valid       (RES_Valid),
        .Busy            (Busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Registered one-bit shift unit; the enable pulse numbered stall_at delays its flag by 3 cycles
    int               en_count = 0;
    int               stall_at = -1;
    logic [WIDTH-1:0] su_out;
    logic             su_pend;
    int               su_cnt;

    assign SU_SHIFT_OUT  = su_out;
    assign SU_SHIFT_Flag = su_pend && (su_cnt == 0);

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            su_out  <= '0;
            su_pend <= 1'b0;
            su_cnt  <= 0;
        end else if (SU_Shift_Enable) begin
            su_out   <= (SU_ALU_FUN == 2'b01) ? (SU_A << 1) : (SU_A >> 1);
            su_pend  <= 1'b1;
            su_cnt   <= (en_count + 1 == stall_at) ? 3 : 0;
            en_count <= en_count + 1;
        end else if (su_pend) begin
            if (su_cnt == 0) su_pend <= 1'b0;
            else su_cnt <= su_cnt - 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_req(input logic [15:0] d, input logic [3:0] a, input logic dir, input bit hold,
                           output logic [15:0] rd, output int lat, output int pulses, output logic bad);
        int e0;
        bad = 1'b0;
        @(negedge CLK);
        check("ready_before_req", 32'(REQ_Ready), 32'd1);
        REQ_Data   = d;
        REQ_Amount = a;
        REQ_Dir    = dir;
        REQ_Valid  = 1'b1;
        e0 = en_count;
        @(posedge CLK);
        lat = 0;
        do begin
            @(negedge CLK);
            if (hold) begin
                REQ_Data   = 16'hFFFF;
                REQ_Amount = '0;
                REQ_Dir    = 1'b0;
            end else begin
                REQ_Valid = 1'b0;
            end
            lat++;
            if (!Busy) bad = 1'b1;
            if (SU_B != '0) bad = 1'b1;
            if (SU_Shift_Enable ? (SU_ALU_FUN != {1'b0, dir}) : (SU_ALU_FUN != 2'b00)) bad = 1'b1;
        end while (!RES_Valid && lat < 100);
        rd     = RES_Data;
        pulses = en_count - e0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  amt;
        logic        dir;
        logic [15:0] exp_data;
        int          exp_lat;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] rd;
        int          lat;
        int          pulses;
        logic        bad;

        vecs[0] = '{16'h8001, 4'd1,  1'b1, 16'h0002, 3,  1};
        vecs[1] = '{16'hF000, 4'd4,  1'b0, 16'h0F00, 9,  4};
        vecs[2] = '{16'h1234, 4'd0,  1'b1, 16'h1234, 1,  0};
        vecs[3] = '{16'hA5A5, 4'd15, 1'b0, 16'h0001, 31, 15};
        vecs[4] = '{16'h00FF, 4'd8,  1'b1, 16'hFF00, 17, 8};
        vecs[5] = '{16'h8421, 4'd3,  1'b0, 16'h1084, 7,  3};

        #1;
        check("rst_ready",  32'(REQ_Ready),       32'd1);
        check("rst_busy",   32'(Busy),            32'd0);
        check("rst_valid",  32'(RES_Valid),       32'd0);
        check("rst_data",   32'(RES_Data),        32'd0);
        check("rst_su_en",  32'(SU_Shift_Enable), 32'd0);
        check("rst_su_a",   32'(SU_A),            32'd0);
        check("rst_su_fun", 32'(SU_ALU_FUN),      32'd0);
        check("rst_su_b",   32'(SU_B),            32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].data, vecs[i].amt, vecs[i].dir, 1'b0, rd, lat, pulses, bad);
            check($sformatf("v%0d_data", i),   32'(rd),     32'(vecs[i].exp_data));
            check($sformatf("v%0d_lat", i),    32'(lat),    32'(vecs[i].exp_lat));
            check($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
            check($sformatf("v%0d_ctrl", i),   32'(bad),    32'd0);
        end

        // Request held valid with changing operands through a full-length run
        run_req(16'h0001, 4'd15, 1'b1, 1'b1, rd, lat, pulses, bad);
        check("hold_data",   32'(rd),     32'h8000);
        check("hold_lat",    32'(lat),    32'd31);
        check("hold_pulses", 32'(pulses), 32'd15);
        check("hold_ctrl",   32'(bad),    32'd0);
        @(negedge CLK);
        check("hold_idle_ready", 32'(REQ_Ready), 32'd1);
        check("hold_idle_valid", 32'(RES_Valid), 32'd0);
        @(negedge CLK);
        REQ_Valid = 1'b0;
        check("hold_next_valid", 32'(RES_Valid), 32'd1);
        check("hold_next_data",  32'(RES_Data),  32'hFFFF);

        // Reset while waiting on the shift unit in an amount-8 operation
        @(negedge CLK);
        REQ_Data   = 16'h00FF;
        REQ_Amount = 4'd8;
        REQ_Dir    = 1'b1;
        REQ_Valid  = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ_Valid = 1'b0;
        @(negedge CLK);
        check("mid_busy_before", 32'(Busy), 32'd1);
        RST = 1'b0;
        #1;
        check("mid_rst_busy",   32'(Busy),            32'd0);
        check("mid_rst_ready",  32'(REQ_Ready),       32'd1);
        check("mid_rst_valid",  32'(RES_Valid),       32'd0);
        check("mid_rst_data",   32'(RES_Data),        32'd0);
        check("mid_rst_su_a",   32'(SU_A),            32'd0);
        check("mid_rst_su_en",  32'(SU_Shift_Enable), 32'd0);
        check("mid_rst_su_fun", 32'(SU_ALU_FUN),      32'd0);
        @(negedge CLK);
        RST = 1'b1;
        run_req(16'h0F0F, 4'd4, 1'b1, 1'b0, rd, lat, pulses, bad);
        check("post_rst_data",   32'(rd),     32'hF0F0);
        check("post_rst_lat",    32'(lat),    32'd9);
        check("post_rst_pulses", 32'(pulses), 32'd4);

        // Second shift pass sees its flag delayed by 3 cycles
        stall_at = en_count + 2;
        run_req(16'hF000, 4'd4, 1'b0, 1'b0, rd, lat, pulses, bad);
        stall_at = -1;
        check("stall_data",   32'(rd),     32'h0F00);
        check("stall_lat",    32'(lat),    32'd12);
        check("stall_pulses", 32'(pulses), 32'd4);
        check("stall_ctrl",   32'(bad),    32'd0);

        @(negedge CLK);
        check("final_hold_data", 32'(RES_Data), 32'h0F00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the datapath width in bits.
REQ-002 The block SHALL have parameter AW, default $clog2(WIDTH), giving the shift-amount width.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port REQ_Valid  input  1  SHALL indicate that a shift request is present.
REQ-006 Port REQ_Ready  output  1  SHALL indicate that the block can accept a request.
REQ-007 Port REQ_Data  input  WIDTH  SHALL carry the operand to be shifted.
REQ-008 Port REQ_Amount  input  AW  SHALL carry the shift distance, 0..WIDTH-1.
REQ-009 Port REQ_Dir  input  1  SHALL select direction: 0 logical right, 1 logical left.
REQ-010 Port SU_A  output  WIDTH  SHALL drive the shift unit A operand.
REQ-011 Port SU_B  output  WIDTH  SHALL drive the shift unit B operand, held at 0.
REQ-012 Port SU_ALU_FUN  output  2  SHALL drive the shift unit function select.
REQ-013 Port SU_Shift_Enable  output  1  SHALL drive the shift unit enable.
REQ-014 Port SU_SHIFT_OUT  input  WIDTH  SHALL carry the registered shift unit result.
REQ-015 Port SU_SHIFT_Flag  input  1  SHALL carry the shift unit result-valid flag.
REQ-016 Port RES_Data  output  WIDTH  SHALL carry the final shifted result.
REQ-017 Port RES_Valid  output  1  SHALL pulse for one cycle when RES_Data is updated.
REQ-018 Port Busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-020 In IDLE, REQ_Ready SHALL be 1; in every other state it SHALL be 0.
REQ-021 When REQ_Valid and REQ_Ready are both high at an edge, the block SHALL capture REQ_Data into a work register, REQ_Amount into a down-counter and REQ_Dir.
REQ-022 After acceptance, amount 0 SHALL go to DONE and a nonzero amount SHALL go to ISSUE.
REQ-023 ISSUE SHALL last one cycle with SU_Shift_Enable=1, SU_A=work, SU_ALU_FUN=2'b01 if Dir=1 else 2'b00, then go to WAIT.
REQ-024 In WAIT, SU_Shift_Enable SHALL be 0 and SU_A SHALL hold the work register.
REQ-025 In WAIT with SU_SHIFT_Flag=1, the block SHALL load SU_SHIFT_OUT into the work register and decrement the counter.
REQ-026 From WAIT, the FSM SHALL go to DONE if the counter reaches 0, otherwise to ISSUE.
REQ-027 In WAIT with SU_SHIFT_Flag=0, the FSM SHALL remain in WAIT with no update.
REQ-028 DONE SHALL last one cycle: RES_Data loads the work register, RES_Valid=1, and the next state is IDLE.
REQ-029 Each shift bit SHALL take 2 cycles; RES_Valid SHALL assert 2N+1 cycles after acceptance for amount N, and 1 cycle after for N=0.
REQ-030 RES_Data SHALL hold its value until the next DONE.
REQ-031 REQ_Valid while Busy SHALL be ignored, with no capture and no state change.
REQ-032 Bits shifted out SHALL be discarded and vacated bits SHALL be zero-filled, as in the shift unit.
REQ-033 Outside ISSUE, SU_Shift_Enable SHALL be 0 and SU_ALU_FUN SHALL be 2'b00.

Reset
REQ-034 Asserting RST, including mid-operation, SHALL immediately force IDLE, zero the work register, counter, Dir and RES_Data, and set RES_Valid=0, SU_Shift_Enable=0, SU_A=0 and SU_ALU_FUN=2'b00.
REQ-035 The first request after reset release SHALL be accepted normally.

Structure
REQ-036 The state encoding typedef and the function constants (FUN_SHR_A=2'b00, FUN_SHL_A=2'b01) SHALL reside in a shared package.
REQ-037 No sub-module SHALL be instantiated; the shift unit SHALL be connected externally at integration level.

Verification
REQ-038 The bench SHALL cover: data 16'h8001, left, amount 1 -> RES_Data 16'h0002, RES_Valid 3 cycles after acceptance.
REQ-039 The bench SHALL cover: data 16'hF000, right, amount 4 -> RES_Data 16'h0F00 after 9 cycles, with exactly 4 SU_Shift_Enable pulses.
REQ-040 The bench SHALL cover: data 16'h1234, amount 0 -> RES_Data 16'h1234 one cycle after acceptance, with no SU_Shift_Enable pulse.
REQ-041 The bench SHALL cover: data 16'h0001, left, amount 15 -> RES_Data 16'h8000 after 31 cycles; a REQ_Valid held during this run is ignored until IDLE.
REQ-042 The bench SHALL cover: RST asserted in WAIT of an amount-8 shift -> all outputs at reset values immediately; a new request after release completes correctly.
REQ-043 The bench SHALL cover: SU_SHIFT_Flag forced low for 3 cycles in WAIT -> FSM holds in WAIT and the result remains correct after release.
